// File: rtl/sec_b2a_serial.sv
// sec_b2a_serial: digit-serial masked Boolean-to-arithmetic converter.
//
// Converts x = b_0 ^ .. ^ b_{n-1} into arithmetic shares with x = a_0 + .. + a_{n-1} mod 2^K.
// a_i (i >= 1) are fresh random words. z = x - r_1 - .. - r_{n-1} is computed on Boolean shares
// by masked ripple subtraction, DIGIT bits per cycle. a_0 is the XOR-fold of a refreshed z.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_vld / o_rdy  input handshake for i_b (N_SHARES Boolean shares, share i at [i*K +: K])
//   rnd / rnd_req  fresh randomness: [K-1:0] r word, then RND_AND SecAnd bits, then N*K
//                  refresh words; rnd_req flags the cycles in which rnd is consumed
//   o_a / o_vld    arithmetic shares (same packing), held stable while o_vld is high
//   i_rdy          downstream accepts o_a
//
// Build option: define SEC_B2A_ZEROIZE_EN to clear z, r, carry and o_a after each handshake
// (and z/carry on FOLD->DONE). Without it these registers hold until the next accept/reset.
module sec_b2a_serial #(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 3,
    parameter int DIGIT    = 4,
    localparam int RND_AND = DIGIT * N_SHARES * (N_SHARES - 1) / 2,
    localparam int RND_W   = K_WIDTH + RND_AND + N_SHARES * K_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_vld,
    output logic                          o_rdy,
    input  logic [N_SHARES*K_WIDTH-1:0]   i_b,
    input  logic [RND_W-1:0]              rnd,
    output logic                          rnd_req,
    output logic [N_SHARES*K_WIDTH-1:0]   o_a,
    output logic                          o_vld,
    input  logic                          i_rdy
);

    localparam int NPAIR = N_SHARES * (N_SHARES - 1) / 2;
    localparam int ND    = K_WIDTH / DIGIT;
    localparam int DW    = (ND > 1) ? $clog2(ND) : 1;
    localparam int PW    = $clog2(N_SHARES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_FOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Carry-in of 1 for the two's-complement "+ 1", held on share 0 only.
    localparam logic [N_SHARES-1:0] CARRY_INIT = N_SHARES'(1);
    localparam logic [K_WIDTH-1:0]  DIGIT_MASK = K_WIDTH'({DIGIT{1'b1}});

    if (K_WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("sec_b2a_serial: K_WIDTH must be a multiple of DIGIT");
    end

    logic [1:0]          state_q;
    logic [PW-1:0]       pass_q;
    logic [DW-1:0]       digit_q;
    logic [K_WIDTH-1:0]  z_q [N_SHARES];
    logic [N_SHARES-1:0] c_q;
    // a_q[0] receives the fold result, a_q[i] (i >= 1) the random word r_i.
    logic [K_WIDTH-1:0]  a_q [N_SHARES];

    logic [K_WIDTH-1:0]  r_cur;
    logic [K_WIDTH-1:0]  z_sub [N_SHARES];
    logic [N_SHARES-1:0] c_sub;
    logic [K_WIDTH-1:0]  z_fold [N_SHARES];
    logic [K_WIDTH-1:0]  a0_fold;

    // One digit of masked ripple addition z + ~r_i (+1 via carry-in).
    always_comb begin
        logic [DIGIT-1:0]    zd [N_SHARES];
        logic [DIGIT-1:0]    zn [N_SHARES];
        logic [DIGIT-1:0]    yd;
        logic [N_SHARES-1:0] c, s, t, zb;
        int                  sh, p;

        sh    = int'(digit_q) * DIGIT;
        // r_i is live on the bus only at digit 0; later digits reuse the stored copy.
        r_cur = (digit_q == '0) ? rnd[K_WIDTH-1:0] : a_q[pass_q];
        yd    = DIGIT'(~r_cur >> sh);
        c     = (digit_q == '0) ? CARRY_INIT : c_q;
        s     = '0;
        t     = '0;
        zb    = '0;
        p     = 0;
        for (int k = 0; k < N_SHARES; k++) begin
            zd[k] = DIGIT'(z_q[k] >> sh);
            zn[k] = '0;
        end
        for (int b = 0; b < DIGIT; b++) begin
            for (int k = 0; k < N_SHARES; k++) begin
                zb[k] = zd[k][b];
                s[k]  = zd[k][b] ^ ((k == 0) ? yd[b] : 1'b0);
            end
            // ISW SecAnd(c, s)
            t = c & s;
            p = 0;
            for (int i = 0; i < N_SHARES; i++) begin
                for (int j = i + 1; j < N_SHARES; j++) begin
                    t[i] = t[i] ^ rnd[K_WIDTH + b * NPAIR + p];
                    t[j] = t[j] ^ rnd[K_WIDTH + b * NPAIR + p] ^ (c[i] & s[j]) ^ (c[j] & s[i]);
                    p++;
                end
            end
            for (int k = 0; k < N_SHARES; k++) begin
                zn[k][b] = s[k] ^ c[k];
            end
            // y is unshared, so z&y is computed share-wise.
            c = ({N_SHARES{yd[b]}} & zb) ^ t;
        end
        c_sub = c;
        for (int k = 0; k < N_SHARES; k++) begin
            z_sub[k] = (z_q[k] & ~(DIGIT_MASK << sh)) | (K_WIDTH'(zn[k]) << sh);
        end
    end

    // Ring refresh: every mask word enters exactly two shares, so the fold is unchanged.
    always_comb begin
        a0_fold = '0;
        for (int k = 0; k < N_SHARES; k++) begin
            z_fold[k] = z_q[k]
                      ^ rnd[K_WIDTH + RND_AND + k * K_WIDTH +: K_WIDTH]
                      ^ rnd[K_WIDTH + RND_AND + ((k + 1) % N_SHARES) * K_WIDTH +: K_WIDTH];
            a0_fold   = a0_fold ^ z_fold[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
            digit_q <= '0;
            c_q     <= '0;
            for (int k = 0; k < N_SHARES; k++) begin
                z_q[k] <= '0;
                a_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_vld) begin
                        for (int k = 0; k < N_SHARES; k++) begin
                            z_q[k] <= i_b[k*K_WIDTH +: K_WIDTH];
                        end
                        pass_q  <= PW'(1);
                        digit_q <= '0;
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    for (int k = 0; k < N_SHARES; k++) begin
                        z_q[k] <= z_sub[k];
                    end
                    c_q <= c_sub;
                    if (digit_q == '0) begin
                        a_q[pass_q] <= r_cur;
                    end
                    if (digit_q == DW'(ND - 1)) begin
                        digit_q <= '0;
                        if (pass_q == PW'(N_SHARES - 1)) begin
                            state_q <= ST_FOLD;
                        end else begin
                            pass_q <= pass_q + PW'(1);
                        end
                    end else begin
                        digit_q <= digit_q + DW'(1);
                    end
                end
                ST_FOLD: begin
                    a_q[0] <= a0_fold;
`ifdef SEC_B2A_ZEROIZE_EN
                    for (int k = 0; k < N_SHARES; k++) begin
                        z_q[k] <= '0;
                    end
                    c_q <= '0;
`else
                    for (int k = 0; k < N_SHARES; k++) begin
                        z_q[k] <= z_fold[k];
                    end
`endif
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_rdy) begin
                        state_q <= ST_IDLE;
`ifdef SEC_B2A_ZEROIZE_EN
                        c_q <= '0;
                        for (int k = 0; k < N_SHARES; k++) begin
                            z_q[k] <= '0;
                            a_q[k] <= '0;
                        end
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_rdy   = (state_q == ST_IDLE);
        o_vld   = (state_q == ST_DONE);
        rnd_req = (state_q == ST_SUB) || (state_q == ST_FOLD);
        o_a     = '0;
        for (int k = 0; k < N_SHARES; k++) begin
            o_a[k*K_WIDTH +: K_WIDTH] = a_q[k];
        end
    end

endmodule

// File: tb/tb_sec_b2a_serial.sv
// Testbench for sec_b2a_serial at default parameters (K=32, N=3, DIGIT=4).
module tb_sec_b2a_serial;

    localparam int K     = 32;
    localparam int N     = 3;
    localparam int ND    = 8;
    localparam int P     = 16;
    localparam int RND_W = 140;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_vld;
    logic             o_rdy;
    logic [N*K-1:0]   i_b;
    logic [RND_W-1:0] rnd;
    logic             rnd_req;
    logic [N*K-1:0]   o_a;
    logic             o_vld;
    logic             i_rdy;

    int tests = 0;
    int fails = 0;
    logic [K-1:0] sb [$];

    always #5 clk = ~clk;

    sec_b2a_serial dut (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_b     (i_b),
        .rnd     (rnd),
        .rnd_req (rnd_req),
        .o_a     (o_a),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: random, 1: all zero, 2: r word all ones, rest random
    function automatic logic [RND_W-1:0] gen_rnd(input int mode);
        logic [RND_W-1:0] v;
        v = '0;
        if (mode != 1) begin
            for (int i = 0; i < 5; i++) v = {v[RND_W-33:0], 32'($urandom)};
        end
        if (mode == 2) v[K-1:0] = '1;
        return v;
    endfunction

    task automatic run_op(input string tag, input logic [K-1:0] x, input logic [K-1:0] m1,
                          input logic [K-1:0] m2, input int mode, input int stall,
                          input int rst_at);
        logic [K-1:0]   r1, r2, sum, exp;
        logic [N*K-1:0] held;
        int             cyc, guard;
        bit             req_ok, stable;
        guard = 0;
        while (o_rdy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " o_rdy before accept"}, o_rdy, 1);
        i_b   = {x ^ m1 ^ m2, m1, m2};
        i_vld = 1'b1;
        rnd   = gen_rnd(mode);
        sb.push_back(x);
        @(negedge clk);
        i_vld  = 1'b0;
        cyc    = 1;
        req_ok = 1'b1;
        r1     = '0;
        r2     = '0;
        while (o_vld !== 1'b1 && cyc < 40) begin
            if (rnd_req !== (cyc >= 1 && cyc <= P + 1)) req_ok = 1'b0;
            rnd = gen_rnd(mode);
            if (cyc == 1) r1 = rnd[K-1:0];
            if (cyc == 1 + ND) r2 = rnd[K-1:0];
            if (cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk({tag, " o_vld after rst"}, o_vld, 0);
                chk({tag, " o_a after rst"}, o_a, 0);
                chk({tag, " o_rdy after rst"}, o_rdy, 1);
                chk({tag, " rnd_req after rst"}, rnd_req, 0);
                void'(sb.pop_back());
                return;
            end
            @(negedge clk);
            cyc++;
        end
        if (rnd_req !== 1'b0) req_ok = 1'b0;
        chk({tag, " latency"}, cyc, P + 2);
        chk({tag, " rnd_req window"}, req_ok, 1);
        chk({tag, " o_rdy in DONE"}, o_rdy, 0);
        sum = o_a[K-1:0] + o_a[2*K-1:K] + o_a[3*K-1:2*K];
        exp = (sb.size() > 0) ? sb.pop_front() : ~x;
        chk({tag, " share sum"}, sum, exp);
        chk({tag, " a1==r1"}, o_a[2*K-1:K], r1);
        chk({tag, " a2==r2"}, o_a[3*K-1:2*K], r2);
        if (stall > 0) begin
            held   = o_a;
            stable = 1'b1;
            i_vld  = 1'b1;
            i_b    = {3{32'h5A5A_5A5A}};
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (o_a !== held || o_vld !== 1'b1 || o_rdy !== 1'b0) stable = 1'b0;
            end
            chk({tag, " hold under stall"}, stable, 1);
        end
        i_rdy = 1'b1;
        @(negedge clk);
        i_rdy = 1'b0;
        chk({tag, " o_rdy after handshake"}, o_rdy, 1);
        chk({tag, " o_vld after handshake"}, o_vld, 0);
        i_vld = 1'b0;
`ifdef SEC_B2A_ZEROIZE_EN
        chk({tag, " o_a zeroized"}, o_a, 0);
`endif
    endtask

    initial begin
        rst   = 1'b1;
        i_vld = 1'b0;
        i_rdy = 1'b0;
        i_b   = '0;
        rnd   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset o_rdy", o_rdy, 1);
        chk("reset o_vld", o_vld, 0);
        chk("reset rnd_req", rnd_req, 0);
        chk("reset o_a", o_a, 0);

        run_op("basic", 32'h1234_5678, $urandom, $urandom, 0, 0, 0);
        run_op("zero_x", 32'h0000_0000, $urandom, $urandom, 2, 0, 0);
        run_op("ones_x", 32'hFFFF_FFFF, $urandom, $urandom, 2, 0, 0);
        run_op("rnd_zero", 32'hA5A5_0F0F, $urandom, $urandom, 1, 0, 0);
        run_op("stall", 32'hDEAD_BEEF, $urandom, $urandom, 0, 5, 0);
        run_op("reset_mid", 32'h0BAD_F00D, $urandom, $urandom, 0, 0, 7);
        run_op("after_rst", 32'hCAFE_BABE, $urandom, $urandom, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
